// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter: default word width,
// the word type and the read-issue FSM states.
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;

  typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_rd_skid_buf.sv
// Small circular buffer that catches words returning from FIFO reads and
// holds them until the downstream stream stage accepts them.
module fifo_rd_skid_buf #(
  parameter int  W     = 16,
  parameter int  DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_data_o,
  output logic [OCC_W-1:0] occupancy_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o     = (occ_q == '0);
  assign full_o      = (occ_q == OCC_W'(DEPTH));
  assign occupancy_o = occ_q;
  assign head_data_o = mem_q[head_q];

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (do_push) tail_d = ptr_next(tail_q);
      if (do_pop)  head_d = ptr_next(head_q);
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // NOTE: storage is reset on purpose: the head entry drives the output word,
  // which must read zero out of reset, and there are only a few entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

endmodule : fifo_rd_skid_buf

// File: rtl/fifo_rd_stream_adapter.sv
// Reads words from a FIFO with one-cycle read latency and presents them as a
// valid/ready stream; counts delivered words and records FIFO underflow.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      words_out,
  output logic                  err_underflow
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  rd_state_e        state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             err_q, err_d;

  logic [OCC_W-1:0] occupancy;
  logic [OCC_W:0]   pending;
  logic             buf_empty, buf_full;
  logic             push, pop, room;

  // A slot is reserved at issue time so a returning word always has room;
  // this is why BUF_DEPTH must be at least 3 to keep one word per cycle.
  assign pending = {1'b0, occupancy} + (OCC_W + 1)'(inflight_q);
  assign room    = pending < (OCC_W + 1)'(BUF_DEPTH);

  assign fifo_rd_en = (state_q == RUN) && !fifo_empty && room && !flush;
  assign inflight_d = fifo_rd_en && !fifo_empty;

  assign push = inflight_q && !flush;
  assign pop  = m_valid && m_ready;

  assign m_valid       = !buf_empty;
  assign busy          = (state_q != IDLE);
  assign words_out     = words_q;
  assign err_underflow = err_q;

  fifo_rd_skid_buf #(
    .W     (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush),
    .push_i      (push),
    .push_data_i (fifo_data_out),
    .pop_i       (pop),
    .head_data_o (m_data),
    .occupancy_o (occupancy),
    .empty_o     (buf_empty),
    .full_o      (buf_full)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = enable ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:  if (enable) state_d = RUN;
        RUN:   if (!enable) state_d = DRAIN;
        DRAIN: begin
          if (enable)                                state_d = RUN;
          else if (occupancy == '0 && !inflight_q)   state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    words_d = pop ? words_q + CNT_W'(1) : words_q;
    // A new underflow wins over a simultaneous clear.
    if (fifo_underflow)  err_d = 1'b1;
    else if (clr_err)    err_d = 1'b0;
    else                 err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      words_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      words_q    <= words_d;
      err_q      <= err_d;
    end
  end

endmodule : fifo_rd_stream_adapter
